// File: rtl/instr_pkg.sv
// Shared constants and types for the instruction queue.
// Word layout: opcode in the top nibble, operand in the low twelve bits.
package instr_pkg;

   localparam int unsigned IQ_WIDTH    = 16;
   localparam int unsigned IQ_DEPTH    = 4;

   localparam int unsigned OPCODE_MSB  = 15;
   localparam int unsigned OPCODE_LSB  = 12;
   localparam int unsigned OPERAND_MSB = 11;
   localparam int unsigned OPERAND_LSB = 0;

   typedef logic [IQ_WIDTH-1:0] instr_t;

endpackage

// File: rtl/instr_queue_store.sv
// DEPTH x WIDTH register file backing the instruction queue.
// One synchronous write port, one combinational read port, async clear on resetN.
module instr_queue_store
   import instr_pkg::*;
#(
   parameter int unsigned WIDTH = IQ_WIDTH,
   parameter int unsigned DEPTH = IQ_DEPTH,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each entry loads only when the write port targets it; cleared to zero on reset.
      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            mem_q[gi] <= '0;
         end else if (we_i && (waddr_i == AW'(gi))) begin
            mem_q[gi] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// Instruction prefetch queue: captures words from the shared bus into a circular
// FIFO and presents the head word to the decoder with 1-cycle fill latency.
// Optional feature: define IR_OVERFLOW_FLAG_EN to add a sticky overflow flag
// that records captures dropped because the queue was full.
module instr_queue
   import instr_pkg::*;
#(
   parameter int unsigned WIDTH = IQ_WIDTH,
   parameter int unsigned DEPTH = IQ_DEPTH,      // must be a power of two
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic [WIDTH-1:0] bus,
   input  logic             inEn,
   input  logic             flush,
   input  logic             instrReady,
   output logic [WIDTH-1:0] instr,
   output logic [3:0]       opcode,
   output logic [11:0]      operand,
   output logic             instrValid,
   output logic             full,
   output logic [LW-1:0]    level
`ifdef IR_OVERFLOW_FLAG_EN
   ,
   output logic             overflow
`endif
);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;
   logic          push, pop, store_we;

   // A full queue still accepts a word when the head leaves on the same edge.
   assign pop      = instrValid & instrReady;
   assign push     = inEn & (~full | pop);
   assign store_we = push & ~flush;

   assign instrValid = (level_q != '0);
   assign full       = (level_q == LW'(DEPTH));
   assign level      = level_q;
   assign opcode     = instr[OPCODE_MSB:OPCODE_LSB];
   assign operand    = instr[OPERAND_MSB:OPERAND_LSB];

   instr_queue_store #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_store (
      .clk     (clk),
      .resetN  (resetN),
      .we_i    (store_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus),
      .raddr_i (rd_ptr_q),
      .rdata_o (instr)
   );

   // Pointer and level update; flush discards validity only, storage keeps its data.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      level_d = level_q + 1'b1;
         else if (pop && !push) level_d = level_q - 1'b1;
      end
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

`ifdef IR_OVERFLOW_FLAG_EN
   logic drop;
   logic overflow_q, overflow_d;

   assign drop     = inEn & full & ~pop;
   assign overflow = overflow_q;

   // Sticky drop indicator; a flush on the same edge as a drop leaves it clear.
   always_comb begin
      overflow_d = overflow_q | drop;
      if (flush) overflow_d = 1'b0;
   end

   // Overflow flag register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) overflow_q <= 1'b0;
      else         overflow_q <= overflow_d;
   end
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_instr_queue;
   import instr_pkg::*;

   localparam int unsigned DEPTH = IQ_DEPTH;

   logic        clk;
   logic        resetN;
   logic [15:0] bus;
   logic        inEn;
   logic        flush;
   logic        instrReady;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [11:0] operand;
   logic        instrValid;
   logic        full;
   logic [2:0]  level;
`ifdef IR_OVERFLOW_FLAG_EN
   logic        overflow;
`endif

   instr_queue dut (
      .clk        (clk),
      .resetN     (resetN),
      .bus        (bus),
      .inEn       (inEn),
      .flush      (flush),
      .instrReady (instrReady),
      .instr      (instr),
      .opcode     (opcode),
      .operand    (operand),
      .instrValid (instrValid),
      .full       (full),
      .level      (level)
`ifdef IR_OVERFLOW_FLAG_EN
      ,
      .overflow   (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_fail   = 0;
   instr_t model_q [$];
   bit     model_ovf = 1'b0;
   instr_t dut_popped [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ":level"}, 32'(level), 32'(model_q.size()));
      chk({tag, ":valid"}, 32'(instrValid), 32'(model_q.size() != 0));
      chk({tag, ":full"},  32'(full), 32'(model_q.size() == DEPTH));
      if (model_q.size() != 0) begin
         chk({tag, ":instr"},   32'(instr),   32'(model_q[0]));
         chk({tag, ":opcode"},  32'(opcode),  32'(model_q[0][15:12]));
         chk({tag, ":operand"}, 32'(operand), 32'(model_q[0][11:0]));
      end
`ifdef IR_OVERFLOW_FLAG_EN
      chk({tag, ":overflow"}, 32'(overflow), 32'(model_ovf));
`endif
   endtask

   // Apply one cycle of inputs, advance the model by the queue rules, then check.
   task automatic step(input logic ie, input logic [15:0] b, input logic rd, input logic fl,
                       input string tag);
      bit mpop, mfull;
      inEn = ie; bus = b; instrReady = rd; flush = fl;
      mpop  = (model_q.size() != 0) && rd;
      mfull = (model_q.size() == DEPTH);
      if (fl) begin
         model_q.delete();
         model_ovf = 1'b0;
      end else begin
         if (mpop) begin
            dut_popped.push_back(instr);
            void'(model_q.pop_front());
         end
         if (ie && (!mfull || mpop)) model_q.push_back(b);
         else if (ie)                model_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
      $display("step %-8s inEn=%0b bus=%h rdy=%0b flush=%0b -> level=%0d valid=%0b head=%h",
               tag, ie, b, rd, fl, level, instrValid, instr);
      check_state(tag);
   endtask

   initial begin
      resetN = 1'b0; bus = '0; inEn = 1'b0; flush = 1'b0; instrReady = 1'b0;

      // Reset state, including cleared storage
      #12;
      check_state("reset");
      chk("reset:instr", 32'(instr), 32'h0);
      resetN = 1'b1;
      @(posedge clk);
      #1;
      check_state("rel");

      // First capture appears one cycle later
      step(1'b1, 16'hA123, 1'b0, 1'b0, "cap");
      chk("cap:opcode", 32'(opcode), 32'hA);
      chk("cap:operand", 32'(operand), 32'h123);
      chk("cap:level", 32'(level), 32'd1);
      step(1'b0, 16'h0000, 1'b0, 1'b1, "flush0");

      // Fill to full, then a dropped capture
      for (int k = 1; k <= 4; k++) step(1'b1, 16'h1000 + 16'(k), 1'b0, 1'b0, "fill");
      step(1'b1, 16'hFFFF, 1'b0, 1'b0, "drop");
      chk("drop:full", 32'(full), 32'h1);
      chk("drop:head", 32'(instr), 32'h1001);
`ifdef IR_OVERFLOW_FLAG_EN
      chk("drop:ovf", 32'(overflow), 32'h1);
`endif

      // Push and pop together while full, then drain
      dut_popped.delete();
      step(1'b1, 16'h2000, 1'b1, 1'b0, "fullpp");
      chk("fullpp:level", 32'(level), 32'd4);
      for (int k = 0; k < 4; k++) step(1'b0, 16'h0000, 1'b1, 1'b0, "drain");
      chk("drain:count", 32'(dut_popped.size()), 32'd5);
      if (dut_popped.size() == 5) begin
         chk("drain:w0", 32'(dut_popped[0]), 32'h1001);
         chk("drain:w1", 32'(dut_popped[1]), 32'h1002);
         chk("drain:w2", 32'(dut_popped[2]), 32'h1003);
         chk("drain:w3", 32'(dut_popped[3]), 32'h1004);
         chk("drain:w4", 32'(dut_popped[4]), 32'h2000);
      end

      // Flush beats a same-edge capture
      for (int k = 0; k < 3; k++) step(1'b1, 16'h3000 + 16'(k), 1'b0, 1'b0, "q3");
      step(1'b1, 16'h5555, 1'b0, 1'b1, "flush");
      chk("flush:level", 32'(level), 32'd0);
      chk("flush:valid", 32'(instrValid), 32'd0);
`ifdef IR_OVERFLOW_FLAG_EN
      chk("flush:ovf", 32'(overflow), 32'd0);
`endif

      // Six words across pointer wrap with simultaneous push/pop
      dut_popped.delete();
      step(1'b1, 16'h0001, 1'b0, 1'b0, "wrap");
      for (int k = 2; k <= 6; k++) step(1'b1, 16'(k), 1'b1, 1'b0, "wrap");
      step(1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
      chk("wrap:count", 32'(dut_popped.size()), 32'd6);
      for (int k = 0; k < dut_popped.size(); k++)
         chk("wrap:word", 32'(dut_popped[k]), 32'(k + 1));

      // Random traffic against the model
      for (int k = 0; k < 300; k++)
         step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0), "rand");

      // Asynchronous reset mid-cycle with two words queued
      step(1'b0, 16'h0000, 1'b0, 1'b1, "preRst");
      step(1'b1, 16'h7001, 1'b0, 1'b0, "preRst");
      step(1'b1, 16'h7002, 1'b0, 1'b0, "preRst");
      chk("preRst:level", 32'(level), 32'd2);
      inEn = 1'b1; bus = 16'h7003; instrReady = 1'b1; flush = 1'b0;
      #3;
      resetN = 1'b0;
      #1;
      model_q.delete();
      model_ovf = 1'b0;
      $display("async reset asserted mid-cycle: level=%0d valid=%0b instr=%h", level, instrValid, instr);
      check_state("arst");
      chk("arst:instr", 32'(instr), 32'h0);
      @(posedge clk);
      #1;
      check_state("arstHold");
      resetN = 1'b1;
      #2;
      inEn = 1'b0;
      @(posedge clk);
      #1;
      check_state("arstRel");
      step(1'b1, 16'hBEEF, 1'b0, 1'b0, "postRst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 16, which sets the bus and instruction word width.
REQ-002 SHALL have parameter DEPTH, default 4, which sets the number of queue entries; DEPTH SHALL be a power of two.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port bus, input, WIDTH bits: the shared tristate system bus, read-only to this block and never driven by it.
REQ-006 SHALL have port inEn, input, 1 bit: capture request that samples bus on this edge.
REQ-007 SHALL have port flush, input, 1 bit: discard all queued words.
REQ-008 SHALL have port instrReady, input, 1 bit: the consumer accepts the head word.
REQ-009 SHALL have port instr, output, WIDTH bits: the head word.
REQ-010 SHALL have port opcode, output, 4 bits: instr[15:12].
REQ-011 SHALL have port operand, output, 12 bits: instr[11:0].
REQ-012 SHALL have port instrValid, output, 1 bit: the head word is valid.
REQ-013 SHALL have port full, output, 1 bit: level equals DEPTH.
REQ-014 SHALL have port level, output, log2(DEPTH)+1 bits: the occupied entry count.
REQ-015 SHALL have port overflow, output, 1 bit: present only under IR_OVERFLOW_FLAG_EN.

Function
REQ-016 SHALL implement a circular FIFO with a write pointer, a read pointer (each log2(DEPTH) bits, wrapping DEPTH-1 to 0) and a level counter.
REQ-017 SHALL treat "push" as inEn=1 AND (full=0 OR pop) at the clock edge, and SHALL write bus into the entry at the write pointer.
REQ-018 SHALL treat "pop" as instrValid=1 AND instrReady=1 at the clock edge, and SHALL advance the read pointer.
REQ-019 SHALL present the head entry combinationally from storage; a word captured at edge N SHALL appear on instr, with instrValid=1, after edge N when the queue was empty (1-cycle latency).
REQ-020 SHALL derive instrValid as level != 0, and opcode/operand SHALL always be slices of instr.
REQ-021 SHALL, on a simultaneous push and pop, leave level unchanged and move both pointers; this SHALL hold when full (the word is accepted).
REQ-022 SHALL ignore pop when empty: pointers and level unchanged.
REQ-023 SHALL, on inEn=1 while full and with no pop, drop the word and leave storage, pointers and level unchanged.
REQ-024 SHALL give flush priority over push and pop: both pointers and level go to 0 on that edge, and bus is not captured.
REQ-025 SHALL NOT clear storage contents on flush; only validity is discarded.

Reset
REQ-026 SHALL, while resetN=0, immediately force pointers=0, level=0, instrValid=0, full=0 and overflow=0, regardless of clk.
REQ-027 SHALL reset storage entries to 0, so instr=0 out of reset.
REQ-028 SHALL discard an in-flight push or pop when reset is asserted mid-operation; the first legal capture is the first rising edge with resetN=1.

Configuration
REQ-029 SHALL, with macro IR_OVERFLOW_FLAG_EN defined, provide port overflow: a sticky flag set on any dropped capture (REQ-023), cleared only by reset or flush; flush wins over a same-edge drop.
REQ-030 SHALL, without IR_OVERFLOW_FLAG_EN, omit both the port and the flag logic; drops are silent.

Structure
REQ-031 SHALL take WIDTH, DEPTH, the opcode/operand field bounds and typedef instr_t from a shared package instr_pkg.
REQ-032 SHALL place storage in one sub-module, instr_queue_store: a DEPTH x WIDTH register file with one write port, one async read port and async clear.

Verification
REQ-033 Bench SHALL cover: reset release, then inEn=1 with bus=16'hA123 for 1 cycle -> next cycle instrValid=1, opcode=4'hA, operand=12'h123, level=1.
REQ-034 Bench SHALL cover: 4 pushes of 16'h1001..16'h1004 with instrReady=0, then inEn=1 with bus=16'hFFFF -> full=1, level=4, head=16'h1001, 16'hFFFF never popped; overflow=1 if enabled.
REQ-035 Bench SHALL cover: full queue with inEn=1, bus=16'h2000 and instrReady=1 on the same edge -> level stays 4, and 16'h2000 is popped 4th after 16'h1002..16'h1004.
REQ-036 Bench SHALL cover: 3 words queued, flush=1 together with inEn=1 -> next cycle level=0, instrValid=0, overflow=0.
REQ-037 Bench SHALL cover: 6 push/pop pairs across pointer wrap with words 16'h0001..16'h0006 -> popped in order, no loss.
REQ-038 Bench SHALL cover: resetN low mid-cycle with level=2 -> outputs zero immediately, before the next clk edge.
